seq_funnel_shifter: RTL and testbench

Multi-cycle, handshaked counterpart to the combinational funnel shifter. It accepts a shift request (operand, amount, mode) on a valid/ready input port. It performs the shift one bit position per clock and returns the result on a valid/ready output port. It sits between a request producer (sequencer or bus adapter) and a result consumer, for area-constrained paths where a full barrel/funnel network is not wanted.

---
 rtl/shift_pkg.sv | 15 +
 rtl/shift_step.sv | 17 +
 rtl/seq_funnel_shifter.sv | 63 ++++++
 tb/tb_seq_funnel_shifter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// shift_pkg: shared mode/state types and mode validity helper for the sequential funnel shifter
package shift_pkg;
  typedef enum logic [2:0] {
    MODE_LSR = 3'b000,
    MODE_LSL = 3'b001,
    MODE_ASR = 3'b010,
    MODE_ASL = 3'b011,
    MODE_ROR = 3'b100,
    MODE_ROL = 3'b101
  } shift_mode_e;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;
  function automatic logic mode_is_valid(input logic [2:0] m);
    return m <= 3'd5;
  endfunction
endpackage

// File: rtl/shift_step.sv
// shift_step: combinational one-bit shift/rotate of a WIDTH-bit value by mode
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_val,
  input  logic [2:0]       i_mode,
  output logic [WIDTH-1:0] o_val
);
  always_comb
    o_val = (i_mode == MODE_LSR) ? {1'b0, i_val[WIDTH-1:1]} :
            (i_mode == MODE_ASR) ? {i_val[WIDTH-1], i_val[WIDTH-1:1]} :
            (i_mode == MODE_ROR) ? {i_val[0], i_val[WIDTH-1:1]} :
            (i_mode == MODE_ROL) ? {i_val[WIDTH-2:0], i_val[WIDTH-1]} :
                                   {i_val[WIDTH-2:0], 1'b0};
endmodule

// File: rtl/seq_funnel_shifter.sv
// seq_funnel_shifter: handshaked shifter applying one bit position per clock
module seq_funnel_shifter
  import shift_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [AMT_W-1:0] amt_i,
  input  logic [2:0]       mode_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] y_o,
  output logic             err_o
);
  state_e           r_state, w_next;
  logic [WIDTH-1:0] r_work, w_step;
  logic [AMT_W-1:0] r_cnt;
  logic [2:0]       r_mode;
  logic             r_err, r_rdy, w_acc;
  shift_step #(.WIDTH(WIDTH)) u_step (.i_val(r_work), .i_mode(r_mode), .o_val(w_step));
  // ready is registered so rst_i never reaches an output combinationally
  assign w_acc = in_valid_i & r_rdy & (r_state == IDLE);
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = !w_acc ? IDLE : (amt_i != '0 && mode_is_valid(mode_i)) ? SHIFT : DONE;
      SHIFT:   w_next = (r_cnt == AMT_W'(1)) ? DONE : SHIFT;
      DONE:    w_next = out_ready_i ? IDLE : DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= IDLE;
      r_work  <= '0;
      r_cnt   <= '0;
      r_mode  <= MODE_LSR;
      r_err   <= 1'b0;
      r_rdy   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_rdy   <= (w_next == IDLE);
      if (w_acc) begin
        r_work <= a_i;
        r_cnt  <= amt_i;
        r_mode <= mode_i;
        r_err  <= !mode_is_valid(mode_i);
      end else if (r_state == SHIFT) begin
        r_work <= w_step;
        r_cnt  <= r_cnt - AMT_W'(1);
      end
    end
  end
  assign in_ready_o  = r_rdy;
  assign out_valid_o = (r_state == DONE);
  assign y_o         = r_work;
  assign err_o       = r_err;
endmodule

// File: tb/tb_seq_funnel_shifter.sv
// tb_seq_funnel_shifter: directed checks of the sequential funnel shifter with WIDTH=4, a=1101
module tb_seq_funnel_shifter;
  logic       clk = 1'b0;
  logic       rst, in_valid, out_ready;
  logic [3:0] a;
  logic [1:0] amt;
  logic [2:0] mode;
  logic       in_ready, out_valid, err;
  logic [3:0] y;
  int checks = 0;
  int errors = 0;
  seq_funnel_shifter #(.WIDTH(4)) dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .a_i(a), .amt_i(amt), .mode_i(mode), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .y_o(y), .err_o(err)
  );
  always #5 clk = ~clk;
  task automatic issue(input logic [1:0] am, input logic [2:0] md, input logic [3:0] exp_y,
                       input logic exp_err, input int exp_lat, input string nm);
    int n, w;
    n = 0;
    w = 0;
    while (!in_ready && w < 20) begin @(posedge clk); #1; w++; end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL %s ready_wait: in_ready=%b required 1", nm, in_ready); end
    a = 4'b1101; amt = am; mode = md; in_valid = 1'b1; out_ready = 1'b1;
    do begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      n++;
      if (n == 1 && exp_lat > 1) begin
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL %s busy_ready: in_ready=%b required 0", nm, in_ready); end
      end
    end while (!out_valid && n < 20);
    checks++;
    if (n !== exp_lat) begin errors++; $display("FAIL %s latency: got %0d required %0d", nm, n, exp_lat); end
    checks++;
    if (y !== exp_y) begin errors++; $display("FAIL %s y: got %b required %b", nm, y, exp_y); end
    checks++;
    if (err !== exp_err) begin errors++; $display("FAIL %s err: got %b required %b", nm, err, exp_err); end
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL %s handoff: out_valid=%b in_ready=%b required 0/1", nm, out_valid, in_ready); end
  endtask
  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; amt = '0; mode = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b required 0", out_valid); end
    checks++;
    if (y !== 4'b0000) begin errors++; $display("FAIL rst_y: got %b required 0000", y); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL rst_err: got %b required 0", err); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b required 0", in_ready); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b required 1", in_ready); end
  endtask
  task automatic test_modes();
    issue(2'd2, 3'b000, 4'b0011, 1'b0, 3, "lsr2");
    issue(2'd1, 3'b001, 4'b1010, 1'b0, 2, "lsl1");
    issue(2'd3, 3'b010, 4'b1111, 1'b0, 4, "asr3");
    issue(2'd2, 3'b011, 4'b0100, 1'b0, 3, "asl2");
    issue(2'd1, 3'b100, 4'b1110, 1'b0, 2, "ror1");
    issue(2'd3, 3'b101, 4'b1110, 1'b0, 4, "rol3");
  endtask
  task automatic test_zero_and_reserved();
    issue(2'd0, 3'b001, 4'b1101, 1'b0, 1, "lsl0");
    issue(2'd0, 3'b100, 4'b1101, 1'b0, 1, "ror0");
    issue(2'd2, 3'b110, 4'b1101, 1'b1, 1, "rsv110");
    issue(2'd1, 3'b111, 4'b1101, 1'b1, 1, "rsv111");
  endtask
  task automatic test_backpressure();
    int n;
    a = 4'b1101; amt = 2'd1; mode = 3'b101; in_valid = 1'b1; out_ready = 1'b0;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
      if (n == 1) mode = 3'b000;
    end while (!out_valid && n < 20);
    checks++;
    if (n !== 2) begin errors++; $display("FAIL bp_latency: got %0d required 2", n); end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (y !== 4'b1011 || out_valid !== 1'b1 || in_ready !== 1'b0)
        begin errors++; $display("FAIL bp_hold%0d: y=%b valid=%b ready=%b required 1011/1/0", i, y, out_valid, in_ready); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      begin errors++; $display("FAIL bp_release: valid=%b ready=%b required 0/1", out_valid, in_ready); end
    n = 0;
    do begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      n++;
    end while (!out_valid && n < 20);
    checks++;
    if (n !== 2 || y !== 4'b0110)
      begin errors++; $display("FAIL bp_second: latency=%0d y=%b required 2/0110", n, y); end
    @(posedge clk); #1;
  endtask
  task automatic test_back_to_back();
    logic [1:0] amts [4] = '{2'd1, 2'd2, 2'd0, 2'd1};
    logic [2:0] modes[4] = '{3'b000, 3'b100, 3'b011, 3'b010};
    logic [3:0] exps [4] = '{4'b0110, 4'b0111, 4'b1101, 4'b1110};
    int idx, ri, last;
    logic rdy, ov;
    logic [3:0] yv;
    idx = 0; ri = 0; last = -1;
    a = 4'b1101; amt = amts[0]; mode = modes[0]; in_valid = 1'b1; out_ready = 1'b1;
    for (int t = 0; t < 60 && ri < 4; t++) begin
      rdy = in_ready; ov = out_valid; yv = y;
      @(posedge clk); #1;
      if (ov) begin
        checks++;
        if (yv !== exps[ri]) begin errors++; $display("FAIL b2b_result%0d: got %b required %b", ri, yv, exps[ri]); end
        ri++;
      end
      if (rdy && idx < 4) begin
        if (last >= 0) begin
          checks++;
          if (t - last !== int'(amts[idx-1]) + 2)
            begin errors++; $display("FAIL b2b_spacing%0d: got %0d required %0d", idx, t - last, int'(amts[idx-1]) + 2); end
        end
        last = t;
        idx++;
        if (idx < 4) begin amt = amts[idx]; mode = modes[idx]; end
        else in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (ri !== 4 || idx !== 4) begin errors++; $display("FAIL b2b_count: results=%0d accepts=%0d required 4/4", ri, idx); end
  endtask
  task automatic test_reset_mid();
    logic saw;
    saw = 1'b0;
    a = 4'b1101; amt = 2'd3; mode = 3'b010; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    saw |= out_valid;
    @(posedge clk); #1;
    saw |= out_valid;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || y !== 4'b0000 || err !== 1'b0 || in_ready !== 1'b0)
      begin errors++; $display("FAIL mid_rst: valid=%b y=%b err=%b ready=%b required 0/0000/0/0", out_valid, y, err, in_ready); end
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b required 1", in_ready); end
    for (int i = 0; i < 4; i++) begin
      saw |= out_valid;
      @(posedge clk); #1;
    end
    checks++;
    if (saw !== 1'b0) begin errors++; $display("FAIL mid_rst_no_result: out_valid seen=%b required 0", saw); end
    issue(2'd1, 3'b010, 4'b1110, 1'b0, 2, "asr1_after_rst");
  endtask
  initial begin
    test_reset();
    test_modes();
    test_zero_and_reserved();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
